seq_divider_16by8: RTL and testbench

- Iterative restoring divider; the inverse operation of the pipelined 8x8 multiplier.
- Divides a 2*WIDTH-bit dividend (e.g. a multiplier product) by a WIDTH-bit divisor, producing one quotient bit per cycle.
- Built around a single subtract-and-compare datapath reused each cycle.
- Sits beside the multiplier in the arithmetic unit and is accessed through a valid/ready request and response handshake.

---
 rtl/seq_divider_16by8.sv | 189 ++++++++++++++++++
 tb/tb_seq_divider_16by8.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/seq_divider_16by8.sv
// Iterative restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor, one quotient bit per clock.
// Define DIV_CHECK_EN to add a registered quotient*divisor+remainder self-check (adds one cycle of latency).
module seq_divider_16by8 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero,
  output logic               chk_err
);

  localparam int CNT_W = $clog2(2*WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(2*WIDTH-1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] DONE  = 2'd3;
`ifdef DIV_CHECK_EN
  localparam logic [1:0] CHECK = 2'd2;
`endif

  logic [1:0]         state_q, state_d;
  logic [2*WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  // Partial remainder is always < divisor, so WIDTH bits hold it between iterations.
  logic [WIDTH-1:0]   pr_q, pr_d;
  logic [2*WIDTH-1:0] quo_q, quo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH:0]     pr_shift;
  logic [WIDTH:0]     pr_sub;
  logic               ge;
  logic [WIDTH-1:0]   pr_next;
  logic [2*WIDTH-1:0] quo_next;
  logic               unused_sub_msb;

`ifdef DIV_CHECK_EN
  logic [2*WIDTH-1:0] dvd_orig_q, dvd_orig_d;
  logic               chk_q, chk_d;

  // Reconstructs the dividend from the result; any carry past 2*WIDTH bits is also a mismatch.
  function automatic logic check_mismatch(input logic [2*WIDTH-1:0] q,
                                          input logic [WIDTH-1:0]   d,
                                          input logic [WIDTH-1:0]   r,
                                          input logic [2*WIDTH-1:0] n);
    logic [3*WIDTH:0] full;
    full = ({{(WIDTH+1){1'b0}}, q} * {{(2*WIDTH+1){1'b0}}, d})
         + {{(2*WIDTH+1){1'b0}}, r};
    return (full[2*WIDTH-1:0] != n) || (|full[3*WIDTH:2*WIDTH]);
  endfunction
`endif

  // Single restoring step: bring in the next dividend bit, subtract if it fits.
  assign pr_shift       = {pr_q, dvd_q[2*WIDTH-1]};
  assign pr_sub         = pr_shift - {1'b0, dvs_q};
  assign ge             = (pr_shift >= {1'b0, dvs_q});
  assign pr_next        = ge ? pr_sub[WIDTH-1:0] : pr_shift[WIDTH-1:0];
  assign quo_next       = {quo_q[2*WIDTH-2:0], ge};
  assign unused_sub_msb = pr_sub[WIDTH];

  always_comb begin
    state_d     = state_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    pr_d        = pr_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
`ifdef DIV_CHECK_EN
    dvd_orig_d  = dvd_orig_q;
    chk_d       = chk_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (divisor != '0) begin
            dvd_d   = dividend;
            dvs_d   = divisor;
            pr_d    = '0;
            quo_d   = '0;
            cnt_d   = '0;
            state_d = BUSY;
`ifdef DIV_CHECK_EN
            dvd_orig_d = dividend;
`endif
          end else begin
            quotient_d  = '1;
            remainder_d = '0;
            dbz_d       = 1'b1;
            state_d     = DONE;
`ifdef DIV_CHECK_EN
            chk_d = 1'b0;
`endif
          end
        end
      end
      BUSY: begin
        dvd_d = {dvd_q[2*WIDTH-2:0], 1'b0};
        pr_d  = pr_next;
        quo_d = quo_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
`ifdef DIV_CHECK_EN
          state_d = CHECK;
`else
          quotient_d  = quo_next;
          remainder_d = pr_next;
          dbz_d       = 1'b0;
          state_d     = DONE;
`endif
        end
      end
`ifdef DIV_CHECK_EN
      CHECK: begin
        quotient_d  = quo_q;
        remainder_d = pr_q;
        dbz_d       = 1'b0;
        chk_d       = check_mismatch(quo_q, dvs_q, pr_q, dvd_orig_q);
        state_d     = DONE;
      end
`endif
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          dbz_d   = 1'b0;
`ifdef DIV_CHECK_EN
          chk_d = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  // Working datapath registers carry no reset; they are reloaded on every accept.
  always_ff @(posedge clk) begin
    dvd_q <= dvd_d;
    dvs_q <= dvs_d;
    pr_q  <= pr_d;
    quo_q <= quo_d;
  end

`ifdef DIV_CHECK_EN
  always_ff @(posedge clk) begin
    dvd_orig_q <= dvd_orig_d;
    if (rst) chk_q <= 1'b0;
    else     chk_q <= chk_d;
  end
  assign chk_err = chk_q;
`else
  assign chk_err = 1'b0;
`endif

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_16by8.sv
// Directed and randomized self-checking bench for seq_divider_16by8.
module tb_seq_divider_16by8;

`ifdef DIV_CHECK_EN
  localparam int NORM_LAT = 18;
`else
  localparam int NORM_LAT = 17;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;
  logic        chk_err;

  int checks = 0;
  int errors = 0;

  seq_divider_16by8 #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .chk_err     (chk_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request, measure latency, check the result, optionally stall the consumer, then drain.
  task automatic do_op(input string tag, input logic [15:0] n, input logic [7:0] d,
                       input logic [15:0] eq, input logic [7:0] er, input logic edbz,
                       input int elat, input int hold);
    int w;
    int lat;
    w = 0;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    dividend = n;
    divisor  = d;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, elat);
    check({tag, "_quotient"}, {16'd0, quotient}, {16'd0, eq});
    check({tag, "_remainder"}, {24'd0, remainder}, {24'd0, er});
    check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, edbz});
    check({tag, "_chk_err"}, {31'd0, chk_err}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      dividend = 16'h0003;
      divisor  = 8'h02;
      tick();
      check({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_hold_ready"}, {31'd0, in_ready}, 32'd0);
      check({tag, "_hold_q"}, {16'd0, quotient}, {16'd0, eq});
      check({tag, "_hold_r"}, {24'd0, remainder}, {24'd0, er});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_drain_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_drain_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_drain_dbz"}, {31'd0, div_by_zero}, 32'd0);
  endtask

  initial begin
    logic [15:0] rn;
    logic [7:0]  rd;
    int          seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    tick();
    tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_quotient", {16'd0, quotient}, 32'd0);
    check("rst_remainder", {24'd0, remainder}, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    check("rst_chk", {31'd0, chk_err}, 32'd0);
    rst = 1'b0;
    tick();

    do_op("fe01_ff", 16'hFE01, 8'hFF, 16'h00FF, 8'h00, 1'b0, NORM_LAT, 0);
    do_op("1000_7", 16'h03E8, 8'h07, 16'h008E, 8'h06, 1'b0, NORM_LAT, 0);
    do_op("5_16", 16'h0005, 8'h10, 16'h0000, 8'h05, 1'b0, NORM_LAT, 0);
    do_op("dbz", 16'h1234, 8'h00, 16'hFFFF, 8'h00, 1'b1, 1, 0);
    do_op("ffff_1", 16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b0, NORM_LAT, 5);
    check("held_after_drain_q", {16'd0, quotient}, 32'h0000FFFF);

    // Abort a division partway through with a one-cycle reset.
    in_valid = 1'b1;
    dividend = 16'h4000;
    divisor  = 8'h03;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_quotient", {16'd0, quotient}, 32'd0);
    check("abort_remainder", {24'd0, remainder}, 32'd0);
    check("abort_dbz", {31'd0, div_by_zero}, 32'd0);
    check("abort_chk", {31'd0, chk_err}, 32'd0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("abort_no_out_valid", seen, 0);
    do_op("4000_3", 16'h4000, 8'h03, 16'h1555, 8'h01, 1'b0, NORM_LAT, 0);

    for (int k = 0; k < 300; k++) begin
      rn = 16'($urandom_range(0, 65535));
      rd = 8'($urandom_range(1, 255));
      do_op("rand", rn, rd, rn / {8'd0, rd}, 8'(rn % {8'd0, rd}), 1'b0, NORM_LAT, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
